// File: rtl/ee357_mcpu_pcir.sv
// PC / IR / Target / retired-count register block paired with the multicycle control unit.
// Supplies decoded instruction fields and immediates back to control and the datapath muxes.
module ee357_mcpu_pcir #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pcw,
  input  logic             pcwc,
  input  logic             irw,
  input  logic             tw,
  input  logic [1:0]       pcs,
  input  logic             zero,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      pc,
  output logic [31:0]      ir,
  output logic [5:0]       op,
  output logic [5:0]       func,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [31:0]      imm_sext,
  output logic [31:0]      imm_sh2,
  output logic [31:0]      target,
  output logic [31:0]      jaddr,
  output logic [CNT_W-1:0] icount,
  output logic             pc_err
);

  localparam logic [5:0]       OP_BNE  = 6'b000101;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic        is_bne;
  logic        take;
  logic        pc_we;
  logic        src_bad;
  logic        misaligned;
  logic [31:0] pc_nxt;

  // Instruction field decode, purely from registered state
  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign func     = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign imm_sh2  = {imm_sext[29:0], 2'b00};
  assign jaddr    = {pc[31:28], ir[25:0], 2'b00};

  // beq takes on zero=1, bne on zero=0; pcw dominates the conditional path
  always_comb begin
    is_bne = (op == OP_BNE);
    take   = pcwc & (zero ^ is_bne);
    pc_we  = pcw | take;
  end

  // Reserved source keeps the current PC but still flags an error
  always_comb begin
    pc_nxt  = pc;
    src_bad = 1'b0;
    case (pcs)
      2'b00:   pc_nxt = alu_result;
      2'b01:   pc_nxt = target;
      2'b10:   pc_nxt = jaddr;
      default: src_bad = 1'b1;
    endcase
    misaligned = (pc_nxt[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      ir     <= '0;
      target <= '0;
      icount <= '0;
      pc_err <= 1'b0;
    end else begin
      if (irw) begin
        ir     <= mem_rdata;
        icount <= icount + CNT_ONE;
      end
      if (tw)
        target <= alu_result;
      if (pc_we) begin
        pc <= pc_nxt;
        if (src_bad || misaligned)
          pc_err <= 1'b1;
      end
    end
  end

endmodule
